// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_HDR0  = 3'd0,
        ST_HDR1  = 3'd1,
        ST_DATA  = 3'd2,
        ST_CSUM  = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

    localparam int unsigned HDR_LEN = 2;
    localparam int unsigned CSUM_W  = 8;
    localparam int unsigned WORD_W  = 32;

    // States in which the loader accepts stream bytes.
    function automatic logic is_accepting(input state_t s);
        return (s == ST_HDR0) || (s == ST_HDR1) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted payload bytes little-endian into 32-bit words.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              accept,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] word_c,
    output logic              word_done_c
);

    logic [1:0]        lane_q, lane_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lane_q  <= '0;
            shreg_q <= '0;
        end else begin
            lane_q  <= lane_d;
            shreg_q <= shreg_d;
        end
    end

    // Current partial word with this cycle's byte dropped into its lane.
    always_comb begin
        lane_d      = lane_q;
        shreg_d     = shreg_q;
        word_c      = shreg_q;
        word_c[{lane_q, 3'b000} +: 8] = byte_in;
        word_done_c = accept && (lane_q == 2'd3);
        if (clear) begin
            lane_d  = '0;
            shreg_d = '0;
        end else if (accept) begin
            lane_d  = 2'(lane_q + 2'd1);
            shreg_d = word_done_c ? '0 : word_c;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a counted byte stream, writes words to instruction
// memory, verifies the XOR checksum and releases the core on success.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned           DEPTH_WORDS = 256,
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    input  logic                  start,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  core_reset,
    output logic                  load_done,
    output logic                  load_error
);

    state_t                state_q, state_d;
    logic [7:0]            cnt_lo_q, cnt_lo_d;
    logic [15:0]           count_q, count_d;
    logic [15:0]           word_index_q, word_index_d;
    logic [CSUM_W-1:0]     xor_q, xor_d;
    logic                  byte_ready_q, byte_ready_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic                  core_reset_q, core_reset_d;
    logic                  load_done_q, load_done_d;
    logic                  load_error_q, load_error_d;

    logic              fire_c;
    logic              pack_accept_c;
    logic              pack_clear_c;
    logic [WORD_W-1:0] word_c;
    logic              word_done_c;
    logic [31:0]       hdr_count_c;
    logic [15:0]       next_index_c;

    byte_packer u_packer (
        .clock       (clock),
        .reset       (reset),
        .clear       (pack_clear_c),
        .accept      (pack_accept_c),
        .byte_in     (byte_in),
        .word_c      (word_c),
        .word_done_c (word_done_c)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_HDR0;
            cnt_lo_q     <= '0;
            count_q      <= '0;
            word_index_q <= '0;
            xor_q        <= '0;
            byte_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= BASE_ADDR;
            mem_wdata_q  <= '0;
            core_reset_q <= 1'b1;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_lo_q     <= cnt_lo_d;
            count_q      <= count_d;
            word_index_q <= word_index_d;
            xor_q        <= xor_d;
            byte_ready_q <= byte_ready_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            core_reset_q <= core_reset_d;
            load_done_q  <= load_done_d;
            load_error_q <= load_error_d;
        end
    end

    assign fire_c        = byte_valid && byte_ready_q;
    assign pack_accept_c = fire_c && (state_q == ST_DATA);
    assign hdr_count_c   = 32'({byte_in, cnt_lo_q});
    assign next_index_c  = 16'(word_index_q + 16'd1);

    always_comb begin
        state_d      = state_q;
        cnt_lo_d     = cnt_lo_q;
        count_d      = count_q;
        word_index_d = word_index_q;
        xor_d        = xor_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        pack_clear_c = 1'b0;

        case (state_q)
            ST_HDR0: begin
                if (fire_c) begin
                    cnt_lo_d = byte_in;
                    state_d  = ST_HDR1;
                end
            end
            ST_HDR1: begin
                if (fire_c) begin
                    count_d = hdr_count_c[15:0];
                    if (hdr_count_c > DEPTH_WORDS) begin
                        state_d = ST_ERROR;
                    end else if (hdr_count_c == 32'd0) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (fire_c) begin
                    xor_d = xor_q ^ byte_in;
                    if (word_done_c) begin
                        mem_we_d     = 1'b1;
                        mem_wdata_d  = word_c;
                        mem_addr_d   = BASE_ADDR + ADDR_WIDTH'({word_index_q, 2'b00});
                        word_index_d = next_index_c;
                        if (next_index_c == count_q) begin
                            state_d = ST_CSUM;
                        end
                    end
                end
            end
            ST_CSUM: begin
                if (fire_c) begin
                    state_d = (byte_in == xor_q) ? ST_DONE : ST_ERROR;
                end
            end
            ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d      = ST_HDR0;
                    word_index_d = '0;
                    xor_d        = '0;
                    pack_clear_c = 1'b1;
                end
            end
            default: state_d = ST_HDR0;
        endcase

        // Status flags follow the state being entered so they are registered.
        byte_ready_d = is_accepting(state_d);
        load_done_d  = (state_d == ST_DONE);
        load_error_d = (state_d == ST_ERROR);
        core_reset_d = (state_d != ST_DONE);
    end

    assign byte_ready = byte_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign core_reset = core_reset_q;
    assign load_done  = load_done_q;
    assign load_error = load_error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a stream-level model predicts writes and outcome.
module tb_imem_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        start = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        core_reset;
    logic        load_done;
    logic        load_error;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t act_q[$];
    logic exp_done;
    logic exp_err;
    int checks = 0;
    int errors = 0;

    imem_loader dut (
        .clock      (clock),
        .reset      (reset),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .start      (start),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .core_reset (core_reset),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Stream-level model: expected writes and final outcome from the byte list.
    task automatic model_load(input logic [7:0] s[$]);
        int n;
        logic [7:0] x;
        exp_q.delete();
        n = int'(s[0]) + 256 * int'(s[1]);
        if (n > 256) begin
            exp_err = 1'b1;
            exp_done = 1'b0;
            return;
        end
        x = 8'h00;
        for (int k = 0; k < n; k++) begin
            wr_t w;
            w.addr = 32'(4 * k);
            w.data = {s[2+4*k+3], s[2+4*k+2], s[2+4*k+1], s[2+4*k]};
            exp_q.push_back(w);
        end
        for (int i = 2; i < 2 + 4 * n; i++) x = x ^ s[i];
        exp_err  = (s[2 + 4 * n] != x);
        exp_done = !exp_err;
    endtask

    // Every cycle: each write must match the next predicted one; status consistent.
    always @(negedge clock) begin
        if (!reset) begin
            if (mem_we) begin
                wr_t a;
                a.addr = mem_addr;
                a.data = mem_wdata;
                act_q.push_back(a);
                if (exp_q.size() == 0) begin
                    chk("unexpected_write_addr", mem_addr, 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("write_addr", mem_addr, e.addr);
                    chk("write_data", mem_wdata, e.data);
                end
            end
            chk("core_reset_vs_done", 32'(core_reset), 32'(!load_done));
            if (load_done || load_error) chk("ready_in_final", 32'(byte_ready), 32'd0);
        end
    end

    // Drive bytes one by one; each waits (bounded) for a ready cycle.
    task automatic send(input logic [7:0] s[$], input bit rnd);
        foreach (s[i]) begin
            int budget = 0;
            bit sent = 0;
            while (!sent) begin
                @(negedge clock);
                budget++;
                if (budget > 200) begin
                    chk("send_timeout", 32'(i), 32'hFFFF_FFFF);
                    byte_valid = 1'b0;
                    return;
                end
                if (rnd && ($urandom_range(0, 1) == 0)) begin
                    byte_valid = 1'b0;
                    byte_in    = 8'(($urandom_range(0, 255)));
                end else begin
                    byte_valid = 1'b1;
                    byte_in    = s[i];
                    if (byte_ready) begin
                        @(posedge clock);
                        sent = 1;
                    end
                end
            end
        end
    endtask

    task automatic final_check(input string tag);
        @(negedge clock);
        byte_valid = 1'b0;
        chk({tag, "_done"}, 32'(load_done), 32'(exp_done));
        chk({tag, "_error"}, 32'(load_error), 32'(exp_err));
        chk({tag, "_core_reset"}, 32'(core_reset), 32'(!exp_done));
        chk({tag, "_ready"}, 32'(byte_ready), 32'd0);
        chk({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic pulse_start(input string tag);
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk({tag, "_restart_done"}, 32'(load_done), 32'd0);
        chk({tag, "_restart_error"}, 32'(load_error), 32'd0);
        chk({tag, "_restart_core_reset"}, 32'(core_reset), 32'd1);
        chk({tag, "_restart_ready"}, 32'(byte_ready), 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ready"}, 32'(byte_ready), 32'd0);
        chk({tag, "_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_addr"}, mem_addr, 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_core_reset"}, 32'(core_reset), 32'd1);
        chk({tag, "_done"}, 32'(load_done), 32'd0);
        chk({tag, "_error"}, 32'(load_error), 32'd0);
    endtask

    initial begin
        logic [7:0] good[$];
        logic [7:0] bad[$];
        logic [7:0] big[$];
        logic [7:0] zero[$];
        logic [7:0] part[$];
        good = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h70, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hF0};
        bad  = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h70, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h00};
        big  = '{8'h01, 8'h01};
        zero = '{8'h00, 8'h00, 8'h00};
        part = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h70};

        // Reset then idle.
        repeat (2) @(negedge clock);
        check_reset_values("rst");
        reset = 1'b0;
        @(negedge clock);
        chk("idle_ready", 32'(byte_ready), 32'd1);
        chk("idle_core_reset", 32'(core_reset), 32'd1);
        chk("idle_we", 32'(mem_we), 32'd0);
        chk("idle_done", 32'(load_done), 32'd0);

        // Good two-word image.
        act_q.delete();
        model_load(good);
        send(good, 0);
        final_check("good");
        chk("good_nwrites", 32'(act_q.size()), 32'd2);
        if (act_q.size() == 2) begin
            chk("good_w0_addr", act_q[0].addr, 32'h0000_0000);
            chk("good_w0_data", act_q[0].data, 32'h0070_0093);
            chk("good_w1_addr", act_q[1].addr, 32'h0000_0004);
            chk("good_w1_data", act_q[1].data, 32'h0000_0013);
        end
        chk("good_done_lit", 32'(load_done), 32'd1);
        pulse_start("good");

        // Bad checksum.
        act_q.delete();
        model_load(bad);
        send(bad, 0);
        final_check("badsum");
        chk("badsum_nwrites", 32'(act_q.size()), 32'd2);
        chk("badsum_error_lit", 32'(load_error), 32'd1);
        pulse_start("badsum");

        // Oversize count 257.
        act_q.delete();
        model_load(big);
        send(big, 0);
        final_check("big");
        chk("big_nwrites", 32'(act_q.size()), 32'd0);
        pulse_start("big");

        // Empty image.
        act_q.delete();
        model_load(zero);
        send(zero, 0);
        final_check("zero");
        chk("zero_nwrites", 32'(act_q.size()), 32'd0);
        pulse_start("zero");

        // Good image with gappy valid.
        act_q.delete();
        model_load(good);
        send(good, 1);
        final_check("gappy");
        chk("gappy_nwrites", 32'(act_q.size()), 32'd2);
        if (act_q.size() == 2) chk("gappy_w1_data", act_q[1].data, 32'h0000_0013);
        pulse_start("gappy");

        // Abort after the third payload byte, then a fresh load.
        model_load(good);
        send(part, 0);
        @(negedge clock);
        byte_valid = 1'b0;
        reset = 1'b1;
        #1;
        check_reset_values("abort");
        exp_q.delete();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        act_q.delete();
        model_load(good);
        send(good, 0);
        final_check("reload");
        chk("reload_nwrites", 32'(act_q.size()), 32'd2);
        if (act_q.size() == 2) chk("reload_w0_data", act_q[0].data, 32'h0070_0093);

        repeat (2) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time writer for the core's instruction memory. It accepts a byte stream over a valid/ready handshake, packs the bytes little-endian into 32-bit words and writes them to consecutive instruction-memory addresses. It holds the core in reset until the whole image has loaded and its checksum has matched. It sits between the host/bench byte source and the write port of instmemo, alongside the riscv top.

Parameters:
DEPTH_WORDS, 256, instruction memory capacity in 32-bit words
ADDR_WIDTH, 32, width of the byte address driven to memory
BASE_ADDR, 0, byte address of the first word written (word aligned)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
byte_in  input  8  stream byte
byte_valid  input  1  byte_in is valid this cycle
byte_ready  output  1  loader accepts byte_in this cycle
start  input  1  one-cycle pulse; restarts a load from DONE or ERROR
mem_we  output  1  instruction memory write strobe, one cycle per word
mem_addr  output  ADDR_WIDTH  byte address of the word being written
mem_wdata  output  32  word being written
core_reset  output  1  reset for the riscv core
load_done  output  1  image loaded and checksum matched
load_error  output  1  checksum mismatch or oversize image

Behaviour:
- One clock domain. Reset is asynchronous and active-high.
- Reset values: byte_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, core_reset=1, load_done=0, load_error=0. State after reset = HDR0.
- A byte is accepted on a clock edge where byte_valid && byte_ready. A byte is never consumed without ready. byte_valid while ready=0 has no effect.
- Stream format: CNT_LO, CNT_HI (16-bit word count N, little-endian), then 4*N payload bytes, then one checksum byte equal to the XOR of all payload bytes.
- States and transitions:
  - HDR0 (ready=1): accepts CNT_LO and moves to HDR1.
  - HDR1 (ready=1): accepts CNT_HI.
    - If N > DEPTH_WORDS, move to ERROR.
    - If N == 0, move to CSUM.
    - Otherwise move to DATA.
  - DATA (ready=1): a byte lane counter 0..3 places the byte at bits [8*lane+7:8*lane].
    - On acceptance of lane 3, the registered outputs on the next edge are: mem_we=1 for exactly one cycle, mem_wdata = assembled word, mem_addr = BASE_ADDR + 4*word_index.
    - word_index then increments.
    - After word N-1 is accepted, move to CSUM.
    - Back-to-back bytes are allowed; ready stays high during the write cycle.
  - CSUM (ready=1): compare the received byte with the running XOR.
    - Equal: move to DONE.
    - Not equal: move to ERROR.
  - DONE (ready=0): load_done=1 and core_reset=0, both registered and effective the cycle after the checksum byte is accepted.
  - ERROR (ready=0): load_error=1 and core_reset stays 1.
  - From DONE or ERROR, start=1 moves to HDR0. On that edge: core_reset=1, load_done=0, load_error=0, word_index=0, lane=0, XOR=0.
  - start in any other state is ignored.
- The running XOR is cleared when HDR0 is entered and updated on every accepted payload byte.
- word_index is 16-bit. mem_addr = BASE_ADDR + (word_index << 2), truncated to ADDR_WIDTH.
- Reset asserted mid-load aborts immediately with all outputs at their reset values. Words already written are not erased.
- mem_addr and mem_wdata hold their last values when mem_we=0.

Decomposition:
- Shared package imem_loader_pkg holds:
  - the state encoding constants (HDR0, HDR1, DATA, CSUM, DONE, ERROR);
  - the header length constant (2);
  - the checksum width constant (8).
- One natural sub-module: byte_packer. It holds the lane counter, the 32-bit shift/insert register and the word-complete pulse. The FSM, address counter and XOR accumulator stay in the top.

Test Plan:
1. Reset asserted, then released with no stream -> core_reset=1, byte_ready=1, mem_we=0, load_done=0.
2. Stream 02 00 93 00 70 00 13 00 00 00 F0 -> two mem_we pulses: addr 00000000 data 00700093, then addr 00000004 data 00000013. load_done=1 and core_reset=0 one cycle after F0 is accepted.
3. Same stream with checksum 00 -> two writes occur, load_error=1, core_reset stays 1, byte_ready=0. A start pulse then returns to HDR0 with load_error=0.
4. Count 0x0101 (257 > 256) -> ERROR after CNT_HI, no mem_we pulses.
5. Count 0 followed by checksum 00 -> DONE with no writes.
6. byte_valid toggled randomly during scenario 2 -> identical writes and result. Separately, reset asserted after the 3rd payload byte -> immediate reset values, and a fresh full load then succeeds.
